// File: rtl/sipo6_frame_ctrl.sv
// Serial frame receiver: start bit, 6 data bits MSB-first, optional even parity, stop bit.
// Good words are committed to a first-word-fall-through FIFO drained by valid/ready.
module sipo6_frame_ctrl #(
  parameter int unsigned PARITY = 0,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_smp,
  input  logic                     i_sin,
  input  logic                     i_dready,
  output logic                     o_dvalid,
  output logic [5:0]               o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_busy,
  output logic                     o_ferr,
  output logic                     o_perr,
  output logic                     o_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StData, StPar, StStop} state_e;

  state_e       r_state, w_state_d;
  logic [2:0]   r_bit, w_bit_d;
  logic [5:0]   r_sh, w_sh_d;
  logic         r_perr, w_perr_d;

  logic [5:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ferr_p, r_perr_p, r_ovf_p;

  logic w_stop_smp, w_push, w_pop, w_full, w_wr;

  always_comb begin
    w_state_d = r_state;
    w_bit_d   = r_bit;
    w_sh_d    = r_sh;
    w_perr_d  = r_perr;
    if (i_smp) begin
      case (r_state)
        StIdle: begin
          if (!i_sin) begin
            w_state_d = StData;
            w_bit_d   = 3'd0;
            w_sh_d    = 6'd0;
            w_perr_d  = 1'b0;
          end
        end
        StData: begin
          w_sh_d  = {r_sh[4:0], i_sin};
          w_bit_d = r_bit + 3'd1;
          if (r_bit == 3'd5) begin
            w_state_d = (PARITY != 0) ? StPar : StStop;
          end
        end
        StPar: begin
          w_perr_d  = (^r_sh) ^ i_sin;
          w_state_d = StStop;
        end
        StStop:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign w_stop_smp = i_smp && (r_state == StStop);
  assign w_push     = w_stop_smp & i_sin & ~r_perr;
  assign w_pop      = o_dvalid & i_dready;
  assign w_full     = (r_count == CountFull);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr       = w_push & (~w_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_bit    <= 3'd0;
      r_sh     <= 6'd0;
      r_perr   <= 1'b0;
      r_ferr_p <= 1'b0;
      r_perr_p <= 1'b0;
      r_ovf_p  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_bit    <= w_bit_d;
      r_sh     <= w_sh_d;
      r_perr   <= w_perr_d;
      r_ferr_p <= w_stop_smp & ~i_sin;
      r_perr_p <= w_stop_smp & i_sin & r_perr;
      r_ovf_p  <= w_push & w_full & ~w_pop;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= r_sh;
    end
  end

  assign o_dvalid = (r_count != '0);
  assign o_dout   = o_dvalid ? r_mem[r_rptr] : 6'd0;
  assign o_count  = r_count;
  assign o_busy   = (r_state != StIdle);
  assign o_ferr   = r_ferr_p;
  assign o_perr   = r_perr_p;
  assign o_ovf    = r_ovf_p;

endmodule

// File: doc/sipo6_frame_ctrl.md
# sipo6_frame_ctrl

Serial frame controller for the 6-bit left-shift series-in path. It detects a start bit on a sampled serial line, sequences six data-bit shifts, checks optional parity and the stop bit, and commits each good 6-bit word into a small first-word-fall-through FIFO. Downstream logic drains the FIFO with a valid/ready handshake. Sits between the bit-rate strobe generator and 6-bit word consumers.

## Interface
- PARITY, 0: 1 = even-parity bit between data and stop; 0 = no parity bit
- DEPTH, 4: FIFO entries; power of two, 2..16
- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset, asynchronous, active-low; one clock, reset asynchronous active-low
- SMP  in  1  bit-sample strobe; SIN is evaluated only in cycles with SMP=1
- SIN  in  1  serial line, idle high
- DREADY  in  1  consumer accepts head word this cycle
- DVALID  out  1  FIFO non-empty
- DOUT  out  6  FIFO head word; 0 when empty
- COUNT  out  $clog2(DEPTH)+1  words held
- BUSY  out  1  frame in progress (state != IDLE)
- FERR  out  1  one-cycle pulse: stop bit sampled 0
- PERR  out  1  one-cycle pulse: parity mismatch, frame dropped
- OVF  out  1  one-cycle pulse: good frame dropped, FIFO full

## Operation
- Reset (async assert): state IDLE, bit counter 0, shift reg 0, FIFO empty; DVALID=0, DOUT=0, COUNT=0, BUSY=0, FERR=PERR=OVF=0.
- States: IDLE, DATA, PAR, STOP. Transitions occur only on SMP=1 cycles, except reset.
- IDLE: SMP & SIN=0 -> DATA, counter=0, shift reg cleared. SIN=1 -> stay.
- DATA: each SMP, shift reg <= {sh[4:0], SIN} (first bit lands in MSB after 6 shifts), counter+1; on 6th shift -> PAR if PARITY=1, else STOP.
- PAR: latch perr = (^sh) ^ SIN (even parity: data XOR parity bit must be 0) -> STOP.
- STOP: SMP with SIN=1 and perr=0 -> push sh; if FIFO full and no pop same cycle -> OVF pulse, word dropped. SIN=1, perr=1 -> PERR pulse, no push. SIN=0 -> FERR pulse (takes priority over PERR), no push. All paths -> IDLE; a SIN=0 stop bit does not count as a new start bit.
- Pop: DVALID & DREADY removes head. DREADY while empty ignored.
- Simultaneous push and pop: both happen; COUNT unchanged; allowed even when full (no OVF).
- FIFO pointers wrap modulo DEPTH; COUNT saturates logically at DEPTH, never exceeds it.
- Reset mid-frame or mid-FIFO: partial frame and all stored words discarded.

## Timing
- Frame = 8 SMP strobes (PARITY=0) or 9 (PARITY=1): start, 6 data, [parity], stop.
- Push registered on the STOP-sample edge; DVALID/DOUT/COUNT reflect it the following cycle (1-cycle latency from stop sample).
- DOUT is FWFT: valid in the same cycle DVALID=1; after a pop, next head visible the next cycle.
- FERR/PERR/OVF high exactly one cycle, the cycle after the stop sample.
- BUSY rises the cycle after the start sample, falls the cycle after the stop sample.
- SMP may be back-to-back (every cycle) or sparse; non-SMP cycles hold state.

## Test plan
- PARITY=0, SMP every cycle, SIN frame 0,1,0,1,1,0,1,1 -> DOUT=6'b101101, DVALID=1 one cycle after stop sample, COUNT=1.
- PARITY=1, data 6'b110000 parity 0 -> accepted; same data with parity 1 -> PERR pulse, COUNT unchanged.
- Stop bit sampled 0 on data 6'b000111 -> FERR pulse, no push, state IDLE, next SIN=0 strobe starts a new frame.
- DEPTH=4, DREADY=0, send 5 good frames -> COUNT=4, OVF pulse on 5th; drain 4 pops -> DOUT in order, DVALID=0, DOUT=0.
- Full FIFO, 5th frame's stop sample coincides with DREADY=1 -> no OVF, COUNT stays 4, new word at tail.
- RST low mid-DATA with COUNT=2 -> all outputs 0 immediately (async); after release, clean frame received correctly.
